// File: rtl/uart_rx_frame_parser_pkg.sv
// Shared constants and types for the UART receive-side command frame parser.
// Holds header bytes, command codes, error codes and the parser state encoding.
package uart_rx_frame_parser_pkg;

    localparam logic [7:0] HDR0_DEF = 8'hA5;
    localparam logic [7:0] HDR1_DEF = 8'h5A;

    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_BAD_CMD = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_CMD  = 3'd2,
        ST_ADDR = 3'd3,
        ST_DATA = 3'd4,
        ST_CSUM = 3'd5
    } parser_state_e;

    function automatic logic is_known_cmd(input logic [7:0] cmd);
        return (cmd == CMD_WR) || (cmd == CMD_RD);
    endfunction

endpackage

// File: rtl/uart_rx_frame_parser_if.sv
// Byte-stream input and decoded-command output bundle of the frame parser.
// Handshake: rx_data_i is meaningful only in the cycle rx_done_i=1; there is no
// backpressure. cmd_valid_o and err_o are single-cycle pulses with no ready.
interface uart_rx_frame_parser_if;
    import uart_rx_frame_parser_pkg::*;

    logic [7:0]    rx_data_i;
    logic          rx_done_i;
    logic          cmd_valid_o;
    logic          cmd_write_o;
    logic [7:0]    cmd_addr_o;
    logic [31:0]   cmd_data_o;
    logic          err_o;
    logic [1:0]    err_code_o;
    logic [7:0]    err_cnt_o;
    parser_state_e dbg_state_o;

    modport master (
        output rx_data_i, rx_done_i,
        input  cmd_valid_o, cmd_write_o, cmd_addr_o, cmd_data_o,
        input  err_o, err_code_o, err_cnt_o, dbg_state_o
    );

    modport slave (
        input  rx_data_i, rx_done_i,
        output cmd_valid_o, cmd_write_o, cmd_addr_o, cmd_data_o,
        output err_o, err_code_o, err_cnt_o, dbg_state_o
    );

endinterface

// File: rtl/uart_rx_timeout.sv
// Inter-byte idle watchdog: counts enabled cycles since the last clear and pulses
// tc_o once the idle window is used up. Reusable by any UART stage.
module uart_rx_timeout #(
    parameter logic [19:0] TIMEOUT_CYC = 20'd13020
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    // tc_o fires in the cycle the count steps to TIMEOUT_CYC-1, so a registered
    // reaction lands exactly TIMEOUT_CYC-1 cycles after the clearing strobe.
    localparam logic [19:0] TC_VAL = TIMEOUT_CYC - 20'd2;

    logic [19:0] cnt_q;

    assign tc_o = en_i && !clr_i && (cnt_q == TC_VAL);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (clr_i || tc_o) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 20'd1;
        end
    end

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Assembles 9-byte command frames from the UART byte stream, checks header and
// XOR checksum, and emits one register command or one error pulse per frame.
module uart_rx_frame_parser
    import uart_rx_frame_parser_pkg::*;
#(
    parameter logic [19:0] TIMEOUT_CYC = 20'd13020,
    parameter logic [7:0]  HDR0        = HDR0_DEF,
    parameter logic [7:0]  HDR1        = HDR1_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    uart_rx_frame_parser_if.slave  bus
);

    parser_state_e state_q;
    parser_state_e state_d;

    logic [7:0]  acc_q;
    logic [1:0]  idx_q;
    logic [7:0]  cmd_q;
    logic [7:0]  addr_q;
    logic [31:0] data_q;

    logic        tmo_tc;
    logic        fire_cmd;
    logic        fire_err;
    logic [1:0]  err_code_d;

    logic        rx_done;
    logic [7:0]  rx_byte;

    assign rx_done = bus.rx_done_i;
    assign rx_byte = bus.rx_data_i;

    uart_rx_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (state_q != ST_IDLE),
        .clr_i   (rx_done),
        .tc_o    (tmo_tc)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tmo_tc) begin
            state_d = ST_IDLE;
        end else if (rx_done) begin
            case (state_q)
                ST_IDLE: if (rx_byte == HDR0) state_d = ST_HDR;
                // A repeated HDR0 keeps us aligned on the newest candidate header.
                ST_HDR: begin
                    if (rx_byte == HDR1)      state_d = ST_CMD;
                    else if (rx_byte != HDR0) state_d = ST_IDLE;
                end
                ST_CMD:  state_d = ST_ADDR;
                ST_ADDR: state_d = ST_DATA;
                ST_DATA: if (idx_q == 2'd3) state_d = ST_CSUM;
                ST_CSUM: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Checksum mismatch outranks an unknown command code.
    always_comb begin
        fire_cmd   = 1'b0;
        fire_err   = 1'b0;
        err_code_d = ERR_NONE;
        if (tmo_tc) begin
            fire_err   = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end else if (rx_done && (state_q == ST_CSUM)) begin
            if (rx_byte != acc_q) begin
                fire_err   = 1'b1;
                err_code_d = ERR_CSUM;
            end else if (!is_known_cmd(cmd_q)) begin
                fire_err   = 1'b1;
                err_code_d = ERR_BAD_CMD;
            end else begin
                fire_cmd = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q  <= '0;
            idx_q  <= '0;
            cmd_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else if (rx_done) begin
            case (state_q)
                ST_CMD: begin
                    cmd_q <= rx_byte;
                    acc_q <= rx_byte;
                end
                ST_ADDR: begin
                    addr_q <= rx_byte;
                    acc_q  <= acc_q ^ rx_byte;
                    idx_q  <= '0;
                end
                ST_DATA: begin
                    data_q <= {data_q[23:0], rx_byte};
                    acc_q  <= acc_q ^ rx_byte;
                    idx_q  <= idx_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus.cmd_valid_o <= 1'b0;
            bus.cmd_write_o <= 1'b0;
            bus.cmd_addr_o  <= '0;
            bus.cmd_data_o  <= '0;
            bus.err_o       <= 1'b0;
            bus.err_code_o  <= ERR_NONE;
            bus.err_cnt_o   <= '0;
        end else begin
            bus.cmd_valid_o <= fire_cmd;
            bus.err_o       <= fire_err;
            if (fire_cmd) begin
                bus.cmd_write_o <= (cmd_q == CMD_WR);
                bus.cmd_addr_o  <= addr_q;
                bus.cmd_data_o  <= data_q;
            end
            if (fire_err) begin
                bus.err_code_o <= err_code_d;
                if (bus.err_cnt_o != 8'hFF) begin
                    bus.err_cnt_o <= bus.err_cnt_o + 8'd1;
                end
            end
        end
    end

    assign bus.dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Directed bench for uart_rx_frame_parser: valid, corrupt, resync, timeout,
// saturation and mid-frame reset scenarios with hand-computed expectations.
module tb_uart_rx_frame_parser;
    import uart_rx_frame_parser_pkg::*;

    localparam int unsigned T = 13020;

    // Frames are HDR0 HDR1 CMD ADDR D3 D2 D1 D0 CSUM, leftmost byte first.
    localparam logic [71:0] F_WR      = 72'hA5_5A_01_10_DE_AD_BE_EF_33;
    localparam logic [71:0] F_RD      = 72'hA5_5A_02_3C_00_00_00_00_3E;
    localparam logic [71:0] F_WR_BAD  = 72'hA5_5A_01_10_DE_AD_BE_EF_32;
    localparam logic [71:0] F_BADCMD  = 72'hA5_5A_07_10_00_00_00_00_17;
    localparam logic [71:0] F_BADBOTH = 72'hA5_5A_07_10_00_00_00_00_16;
    localparam logic [71:0] F_RS      = 72'hA5_5A_01_20_12_34_56_78_29;

    logic clk_i;
    logic rst_n_i;
    int   checks;
    int   errors;
    logic seen;

    uart_rx_frame_parser_if bus ();

    uart_rx_frame_parser #(
        .TIMEOUT_CYC (20'(T)),
        .HDR0        (8'hA5),
        .HDR1        (8'h5A)
    ) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not reach its end (time %0t)", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One idle cycle before each strobe keeps rx_done_i from ever repeating back to back.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_i);
        #1;
        bus.rx_data_i = b;
        bus.rx_done_i = 1'b1;
        @(posedge clk_i);
        #1;
        bus.rx_done_i = 1'b0;
        bus.rx_data_i = 8'h00;
    endtask

    task automatic send_bytes(input logic [71:0] f, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            send_byte(f[71 - 8*i -: 8]);
        end
    endtask

    task automatic send_frame(input logic [71:0] f);
        send_bytes(f, 0, 8);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus.cmd_valid_o), 32'd0);
        check({tag, "_write"}, 32'(bus.cmd_write_o), 32'd0);
        check({tag, "_addr"},  32'(bus.cmd_addr_o),  32'd0);
        check({tag, "_data"},  bus.cmd_data_o,       32'd0);
        check({tag, "_err"},   32'(bus.err_o),       32'd0);
        check({tag, "_code"},  32'(bus.err_code_o),  32'd0);
        check({tag, "_cnt"},   32'(bus.err_cnt_o),   32'd0);
        check({tag, "_state"}, 32'(bus.dbg_state_o), 32'(ST_IDLE));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n_i = 1'b0;
        bus.rx_done_i = 1'b0;
        bus.rx_data_i = 8'h00;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        rst_n_i = 1'b1;

        // Write command
        send_frame(F_WR);
        check("wr_valid", 32'(bus.cmd_valid_o), 32'd1);
        check("wr_write", 32'(bus.cmd_write_o), 32'd1);
        check("wr_addr",  32'(bus.cmd_addr_o),  32'h10);
        check("wr_data",  bus.cmd_data_o,       32'hDEADBEEF);
        check("wr_err",   32'(bus.err_o),       32'd0);
        check("wr_cnt",   32'(bus.err_cnt_o),   32'd0);
        @(posedge clk_i);
        #1;
        check("wr_pulse_end", 32'(bus.cmd_valid_o), 32'd0);
        check("wr_data_hold", bus.cmd_data_o,       32'hDEADBEEF);
        check("wr_state_idle", 32'(bus.dbg_state_o), 32'(ST_IDLE));

        // Read command: data bytes still flow into cmd_data_o
        send_frame(F_RD);
        check("rd_valid", 32'(bus.cmd_valid_o), 32'd1);
        check("rd_write", 32'(bus.cmd_write_o), 32'd0);
        check("rd_addr",  32'(bus.cmd_addr_o),  32'h3C);
        check("rd_data",  bus.cmd_data_o,       32'h0);

        // Checksum error
        send_frame(F_WR_BAD);
        check("cs_err",   32'(bus.err_o),       32'd1);
        check("cs_code",  32'(bus.err_code_o),  32'(ERR_CSUM));
        check("cs_valid", 32'(bus.cmd_valid_o), 32'd0);
        check("cs_cnt",   32'(bus.err_cnt_o),   32'd1);
        check("cs_addr_hold", 32'(bus.cmd_addr_o), 32'h3C);
        @(posedge clk_i);
        #1;
        check("cs_err_pulse_end", 32'(bus.err_o), 32'd0);
        check("cs_code_hold", 32'(bus.err_code_o), 32'(ERR_CSUM));

        // Unknown command with good checksum, then with bad checksum
        send_frame(F_BADCMD);
        check("bc_err",   32'(bus.err_o),       32'd1);
        check("bc_code",  32'(bus.err_code_o),  32'(ERR_BAD_CMD));
        check("bc_valid", 32'(bus.cmd_valid_o), 32'd0);
        check("bc_cnt",   32'(bus.err_cnt_o),   32'd2);
        send_frame(F_BADBOTH);
        check("prio_code", 32'(bus.err_code_o), 32'(ERR_CSUM));
        check("prio_cnt",  32'(bus.err_cnt_o),  32'd3);

        // Header resync on repeated HDR0, and silent drop of a broken header
        send_byte(8'hA5);
        send_frame(F_RS);
        check("rs_valid", 32'(bus.cmd_valid_o), 32'd1);
        check("rs_addr",  32'(bus.cmd_addr_o),  32'h20);
        check("rs_data",  bus.cmd_data_o,       32'h12345678);
        send_byte(8'hA5);
        send_byte(8'h11);
        check("hdr_drop_state", 32'(bus.dbg_state_o), 32'(ST_IDLE));
        check("hdr_drop_err",   32'(bus.err_o),       32'd0);
        check("hdr_drop_cnt",   32'(bus.err_cnt_o),   32'd3);

        // Timeout after ADDR: error lands T-1 cycles after the last strobe
        send_bytes(F_WR, 0, 3);
        seen = 1'b0;
        for (int k = 1; k <= T - 2; k++) begin
            @(posedge clk_i);
            #1;
            if (bus.err_o) seen = 1'b1;
        end
        check("tmo_early", 32'(seen), 32'd0);
        @(posedge clk_i);
        #1;
        check("tmo_err",   32'(bus.err_o),       32'd1);
        check("tmo_code",  32'(bus.err_code_o),  32'(ERR_TIMEOUT));
        check("tmo_cnt",   32'(bus.err_cnt_o),   32'd4);
        check("tmo_state", 32'(bus.dbg_state_o), 32'(ST_IDLE));
        send_frame(F_WR);
        check("tmo_next_valid", 32'(bus.cmd_valid_o), 32'd1);
        check("tmo_next_data",  bus.cmd_data_o,       32'hDEADBEEF);

        // Byte arriving in the terminal-count cycle wins over the timeout
        send_bytes(F_WR, 0, 1);
        seen = 1'b0;
        for (int k = 1; k <= T - 3; k++) begin
            @(posedge clk_i);
            #1;
            if (bus.err_o) seen = 1'b1;
        end
        send_bytes(F_WR, 2, 2);
        if (bus.err_o) seen = 1'b1;
        send_bytes(F_WR, 3, 8);
        check("race_no_err", 32'(seen),            32'd0);
        check("race_valid",  32'(bus.cmd_valid_o), 32'd1);
        check("race_cnt",    32'(bus.err_cnt_o),   32'd4);

        // Error counter saturation
        for (int i = 0; i < 300; i++) begin
            send_frame(F_WR_BAD);
            if (i == 249) check("sat_fe", 32'(bus.err_cnt_o), 32'hFE);
        end
        check("sat_ff",   32'(bus.err_cnt_o),  32'hFF);
        check("sat_code", 32'(bus.err_code_o), 32'(ERR_CSUM));

        // Reset mid-frame
        send_bytes(F_WR, 0, 3);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b0;
        #2;
        check_reset_outputs("midrst");
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        send_frame(F_RD);
        check("post_rst_valid", 32'(bus.cmd_valid_o), 32'd1);
        check("post_rst_addr",  32'(bus.cmd_addr_o),  32'h3C);
        check("post_rst_write", 32'(bus.cmd_write_o), 32'd0);
        check("post_rst_cnt",   32'(bus.err_cnt_o),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
